// File: rtl/cmd_issue_decoder.sv
// Issue FIFO feeding a DDR3 command-pin encoder with power-down / tXP sequencing.
// Define ISSUE_OUT_REG_EN to add a second register stage on all pin outputs and cmd_issued.

package cmd_issue_pkg;
    localparam int ROW_BITS  = 14;
    localparam int COL_BITS  = 10;
    localparam int BA_BITS   = 3;
    localparam int ADDR_BITS = 14;

    // Codes 8..15 are undefined and encode as NOP while still counting as issued.
    typedef enum logic [3:0] {
        CMD_NOP       = 4'd0,
        CMD_ACTIVE    = 4'd1,
        CMD_READ      = 4'd2,
        CMD_WRITE     = 4'd3,
        CMD_PRECHARGE = 4'd4,
        CMD_REFRESH   = 4'd5,
        CMD_POWER_D   = 4'd6,
        CMD_POWER_U   = 4'd7
    } sch_cmd_t;

    typedef struct packed {
        sch_cmd_t                     cmd;
        logic [ROW_BITS+COL_BITS-1:0] addr;
        logic [BA_BITS-1:0]           bank;
    } issue_fifo_cmd_in_t;
endpackage

module cmd_issue_decoder
    import cmd_issue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TXP        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  issue_fifo_cmd_in_t            in_cmd,
    output logic                          in_ready,
    output logic                          ddr_cke,
    output logic                          ddr_cs_n,
    output logic                          ddr_ras_n,
    output logic                          ddr_cas_n,
    output logic                          ddr_we_n,
    output logic [BA_BITS-1:0]            ddr_ba,
    output logic [ADDR_BITS-1:0]          ddr_addr,
    output logic                          cmd_issued,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    dbg_state
);
    // Handshake: an entry is accepted on a rising edge where in_valid && in_ready;
    // in_ready depends only on occupancy, never on in_valid or a same-cycle pop.
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CTW = (TXP > 1) ? $clog2(TXP) : 1;

    typedef enum logic [1:0] {S_RUN = 2'd0, S_PD = 2'd1, S_TXP = 2'd2} state_t;

    typedef struct packed {
        logic                 cke;
        logic                 cs_n;
        logic                 ras_n;
        logic                 cas_n;
        logic                 we_n;
        logic [BA_BITS-1:0]   ba;
        logic [ADDR_BITS-1:0] addr;
        logic                 issued;
    } pin_t;

    localparam pin_t PIN_RST = '{cke: 1'b0, cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1,
                                 we_n: 1'b1, ba: '0, addr: '0, issued: 1'b0};

    issue_fifo_cmd_in_t mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               push, pop, empty;
    issue_fifo_cmd_in_t head;

    state_t             state, state_d;
    logic [CTW-1:0]     cnt, cnt_d;
    pin_t               pin_d, pin_q, pin_o;

    assign empty      = (count == '0);
    assign in_ready   = (count != CW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Pop permission and next state; in power-down only POWER_U may leave the FIFO.
    always_comb begin
        pop     = 1'b0;
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_RUN: begin
                pop = !empty;
                if (pop && head.cmd == CMD_POWER_D) state_d = S_PD;
            end
            S_PD: begin
                pop = !empty && (head.cmd == CMD_POWER_U);
                if (pop) begin
                    state_d = S_TXP;
                    cnt_d   = CTW'(TXP - 1);
                end
            end
            S_TXP: begin
                if (cnt == '0) state_d = S_RUN;
                else           cnt_d   = cnt - CTW'(1);
            end
            default: state_d = S_RUN;
        endcase
    end

    // Pin encoding of the popped head; cke low for every cycle spent in power-down.
    always_comb begin
        pin_d        = '0;
        pin_d.cke    = (state_d != S_PD);
        pin_d.issued = pop;
        {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} = 4'b0111;
        if (pop) begin
            case (head.cmd)
                CMD_ACTIVE: begin
                    {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} = 4'b0011;
                    pin_d.addr = head.addr[ROW_BITS+COL_BITS-1:COL_BITS];
                    pin_d.ba   = head.bank;
                end
                CMD_READ, CMD_WRITE: begin
                    {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} =
                        (head.cmd == CMD_READ) ? 4'b0101 : 4'b0100;
                    pin_d.addr     = ADDR_BITS'(head.addr[COL_BITS-1:0]);
                    pin_d.addr[10] = 1'b0;
                    pin_d.ba       = head.bank;
                end
                CMD_PRECHARGE: begin
                    {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} = 4'b0010;
                    pin_d.ba = head.bank;
                end
                CMD_REFRESH: begin
                    {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} = 4'b0001;
                end
                default: begin
                    {pin_d.cs_n, pin_d.ras_n, pin_d.cas_n, pin_d.we_n} = 4'b0111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pin_q <= PIN_RST;
        else     pin_q <= pin_d;
    end

`ifdef ISSUE_OUT_REG_EN
    pin_t pin_q2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pin_q2 <= PIN_RST;
        else     pin_q2 <= pin_q;
    end
    assign pin_o = pin_q2;
`else
    assign pin_o = pin_q;
`endif

    assign ddr_cke    = pin_o.cke;
    assign ddr_cs_n   = pin_o.cs_n;
    assign ddr_ras_n  = pin_o.ras_n;
    assign ddr_cas_n  = pin_o.cas_n;
    assign ddr_we_n   = pin_o.we_n;
    assign ddr_ba     = pin_o.ba;
    assign ddr_addr   = pin_o.addr;
    assign cmd_issued = pin_o.issued;
endmodule

// File: tb/tb_cmd_issue_decoder.sv
// Bench for cmd_issue_decoder: directed scenarios plus random traffic against a
// queue-based reference model; honours ISSUE_OUT_REG_EN for output latency.
module tb_cmd_issue_decoder;
    import cmd_issue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TXP   = 3;
    localparam int OW    = 23;
`ifdef ISSUE_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [OW-1:0] OUT_RST = {1'b0, 4'b1111, 3'b000, 14'h0, 1'b0};

    logic               clk, rst, in_valid, in_ready;
    issue_fifo_cmd_in_t in_cmd;
    logic               ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, cmd_issued;
    logic [2:0]         ddr_ba;
    logic [13:0]        ddr_addr;
    logic [2:0]         fifo_count;
    logic [1:0]         dbg_state;
    logic [OW-1:0]      obs;

    cmd_issue_decoder #(.FIFO_DEPTH(DEPTH), .TXP(TXP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_cmd(in_cmd), .in_ready(in_ready),
        .ddr_cke(ddr_cke), .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n),
        .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n), .ddr_ba(ddr_ba),
        .ddr_addr(ddr_addr), .cmd_issued(cmd_issued), .fifo_count(fifo_count),
        .dbg_state(dbg_state)
    );

    assign obs = {ddr_cke, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n, ddr_ba, ddr_addr, cmd_issued};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queued entries, power-down flag, edges still barred after POWER_U.
    issue_fifo_cmd_in_t q[$];
    bit                 pd;
    int                 hold;
    logic [OW-1:0]      exp_q[$];
    logic [OW-1:0]      exp_now;
    int                 checks, errors;

    function automatic issue_fifo_cmd_in_t mk(sch_cmd_t c, logic [13:0] row,
                                              logic [9:0] col, logic [2:0] bank);
        issue_fifo_cmd_in_t r;
        r.cmd  = c;
        r.addr = {row, col};
        r.bank = bank;
        return r;
    endfunction

    function automatic logic [OW-1:0] encode(issue_fifo_cmd_in_t e, bit cke);
        logic [3:0]  p;
        logic [2:0]  ba;
        logic [13:0] a;
        p = 4'b0111; ba = 3'd0; a = 14'd0;
        case (e.cmd)
            CMD_ACTIVE:    begin p = 4'b0011; a = e.addr[23:10]; ba = e.bank; end
            CMD_READ:      begin p = 4'b0101; a = {4'd0, e.addr[9:0]}; a[10] = 1'b0; ba = e.bank; end
            CMD_WRITE:     begin p = 4'b0100; a = {4'd0, e.addr[9:0]}; a[10] = 1'b0; ba = e.bank; end
            CMD_PRECHARGE: begin p = 4'b0010; ba = e.bank; end
            CMD_REFRESH:   p = 4'b0001;
            default:       p = 4'b0111;
        endcase
        return {cke, p, ba, a, 1'b1};
    endfunction

    task automatic model_reset();
        q.delete();
        pd   = 1'b0;
        hold = 0;
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(OUT_RST);
        exp_now = OUT_RST;
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (obs === exp_now) else begin
            errors++;
            $error("FAIL %s pins observed=%h expected=%h", tag, obs, exp_now);
        end
        checks++;
        assert (fifo_count === 3'(q.size())) else begin
            errors++;
            $error("FAIL %s fifo_count observed=%0d expected=%0d", tag, fifo_count, q.size());
        end
        checks++;
        assert (in_ready === (q.size() < DEPTH)) else begin
            errors++;
            $error("FAIL %s in_ready observed=%b expected=%b", tag, in_ready, q.size() < DEPTH);
        end
    endtask

    // One clock: drive inputs, predict the edge, then check at the following negedge.
    task automatic step(input bit v, input issue_fifo_cmd_in_t e, input string tag);
        bit                 ready, can_pop;
        issue_fifo_cmd_in_t h;
        logic [OW-1:0]      nxt;
        in_valid = v;
        in_cmd   = e;
        ready    = (q.size() < DEPTH);
        can_pop  = 1'b0;
        if (!pd && hold > 0) hold--;
        else if (q.size() > 0) can_pop = pd ? (q[0].cmd == CMD_POWER_U) : 1'b1;
        if (can_pop) begin
            h = q.pop_front();
            if (!pd && h.cmd == CMD_POWER_D) pd = 1'b1;
            else if (pd) begin pd = 1'b0; hold = TXP; end
            nxt = encode(h, !pd);
        end else begin
            nxt = {!pd, 4'b0111, 3'd0, 14'd0, 1'b0};
        end
        if (v && ready) q.push_back(e);
        exp_q.push_back(nxt);
        exp_now = exp_q.pop_front();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, mk(CMD_NOP, 14'd0, 10'd0, 3'd0), tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit                 force_pu;
        bit                 v;
        issue_fifo_cmd_in_t e;
        sch_cmd_t           c;
        checks = 0; errors = 0; force_pu = 1'b0;
        in_valid = 1'b0;
        in_cmd   = '0;
        rst      = 1'b1;
        model_reset();
        #12 check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2, "cke_rise");

        // ACTIVE bank 2 row 0x1A5
        step(1'b1, mk(CMD_ACTIVE, 14'h1A5, 10'h0, 3'd2), "act_push");
        idle(4, "act_pins");

        // power-down, power-up, then READ held through tXP
        step(1'b1, mk(CMD_POWER_D, 14'h0, 10'h0, 3'd0), "pd_push");
        step(1'b1, mk(CMD_POWER_U, 14'h0, 10'h0, 3'd0), "pu_push");
        step(1'b1, mk(CMD_READ, 14'h0, 10'h040, 3'd1), "rd_push");
        idle(8, "txp_read");

        // count held at 2 across pointer wrap
        step(1'b1, mk(CMD_POWER_D, 14'h0, 10'h0, 3'd0), "wrap_pd");
        step(1'b1, mk(CMD_POWER_U, 14'h0, 10'h0, 3'd0), "wrap_pu");
        idle(2, "wrap_gap");
        for (int i = 0; i < 12; i++)
            step(1'b1, mk((i % 2) ? CMD_WRITE : CMD_READ, 14'h0, 10'(i * 37), 3'(i)), "wrap_flow");
        idle(6, "wrap_drain");

        // other encodings, POWER_U in run, undefined code
        step(1'b1, mk(CMD_PRECHARGE, 14'h3FF, 10'h3FF, 3'd5), "pre");
        step(1'b1, mk(CMD_REFRESH, 14'h123, 10'h2AA, 3'd7), "ref");
        step(1'b1, mk(CMD_POWER_U, 14'h1, 10'h1, 3'd1), "pu_run");
        step(1'b1, mk(sch_cmd_t'(4'd11), 14'h55, 10'h55, 3'd3), "undef");
        step(1'b1, mk(CMD_WRITE, 14'h0, 10'h7FF, 3'd6), "wr_a10");
        idle(4, "enc_drain");

        // fill while held in power-down; fifth push refused
        step(1'b1, mk(CMD_POWER_D, 14'h0, 10'h0, 3'd0), "full_pd");
        idle(1, "full_gap");
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(CMD_READ, 14'h0, 10'(i + 1), 3'd0), "full_push");
        idle(3, "full_hold");
        async_reset("rst_pd");
        idle(2, "post_rst_pd");

        // reset while in tXP with three queued
        step(1'b1, mk(CMD_POWER_D, 14'h0, 10'h0, 3'd0), "txp_pd");
        step(1'b1, mk(CMD_POWER_U, 14'h0, 10'h0, 3'd0), "txp_pu");
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(CMD_READ, 14'h0, 10'(i + 8), 3'd2), "txp_fill");
        async_reset("rst_txp");
        idle(6, "post_rst_txp");

        // random traffic; every accepted POWER_D is followed by a POWER_U
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            if (force_pu) c = CMD_POWER_U;
            else begin
                case ($urandom_range(0, 9))
                    0:       c = CMD_ACTIVE;
                    1, 9:    c = CMD_READ;
                    2:       c = CMD_WRITE;
                    3:       c = CMD_PRECHARGE;
                    4:       c = CMD_REFRESH;
                    5:       c = CMD_NOP;
                    6:       c = CMD_POWER_D;
                    7:       c = CMD_POWER_U;
                    default: c = sch_cmd_t'(4'($urandom_range(8, 15)));
                endcase
            end
            e = mk(c, 14'($urandom), 10'($urandom), 3'($urandom));
            if (v && q.size() < DEPTH) begin
                if (c == CMD_POWER_D)      force_pu = 1'b1;
                else if (c == CMD_POWER_U) force_pu = 1'b0;
            end
            step(v, e, "random");
        end
        idle(12, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
